// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/subtract unit with valid/ready handshake on both sides.
// S1 registers the operands, S2 registers sum/diff/flag; done_cnt counts consumed results.
module addsub_pipe #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH-1:0] diff,
    output logic             diff_ovf,
    output logic [CNT_W-1:0] done_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_full;
    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;

    // Ready chain depends only on state and out_ready, never on in_valid.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        a_ext     = {((SIGNED != 0) & s1_a[WIDTH-1]), s1_a};
        b_ext     = {((SIGNED != 0) & s1_b[WIDTH-1]), s1_b};
        sum_c     = a_ext + b_ext;
        diff_full = {1'b0, s1_a} - {1'b0, s1_b};
        diff_c    = diff_full[WIDTH-1:0];
        if (SIGNED != 0) begin
            ovf_c = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff_c[WIDTH-1] != s1_a[WIDTH-1]);
        end else begin
            // The extra bit of the zero-extended subtraction is the borrow.
            ovf_c = diff_full[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b;
            end
        end
    end

    // S2 only loads when it may advance, so outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            diff     <= '0;
            diff_ovf <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum      <= sum_c;
                diff     <= diff_c;
                diff_ovf <= ovf_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench: an unsigned (CNT_W=3) and a signed (CNT_W=8) instance share
// the same handshake stimulus; expected results are hand-computed per vector.
module tb_addsub_pipe;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] us;
        logic [3:0] ud;
        logic       uo;
        logic [4:0] ss;
        logic [3:0] sd;
        logic       so;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    logic       u_in_ready, u_out_valid, u_ovf;
    logic [4:0] u_sum;
    logic [3:0] u_diff;
    logic [2:0] u_done_cnt;
    logic       s_in_ready, s_out_valid, s_ovf;
    logic [4:0] s_sum;
    logic [3:0] s_diff;
    logic [7:0] s_done_cnt;

    vec_t vecs [16];
    vec_t exp_q [$];
    int   checks;
    int   errors;
    int   model_cnt;
    int   accepts;
    int   or_mode;

    addsub_pipe #(.WIDTH(4), .SIGNED(0), .CNT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .a(a), .b(b), .out_valid(u_out_valid), .out_ready(out_ready),
        .sum(u_sum), .diff(u_diff), .diff_ovf(u_ovf), .done_cnt(u_done_cnt)
    );

    addsub_pipe #(.WIDTH(4), .SIGNED(1), .CNT_W(8)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
        .sum(s_sum), .diff(s_diff), .diff_ovf(s_ovf), .done_cnt(s_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready driver: 0 = held low, 1 = held high, 2 = random per cycle
    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops and compares on every cycle a result will be consumed.
    always @(negedge clk) begin
        vec_t e;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            chk("u_done_cnt", int'(u_done_cnt), model_cnt % 8);
            chk("s_done_cnt", int'(s_done_cnt), model_cnt % 256);
            if (u_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result sum=%0d with empty scoreboard, expected none", u_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("u_sum", int'(u_sum), int'(e.us));
                    chk("u_diff", int'(u_diff), int'(e.ud));
                    chk("u_ovf", int'(u_ovf), int'(e.uo));
                    chk("s_out_valid", int'(s_out_valid), 1);
                    chk("s_sum", int'(s_sum), int'(e.ss));
                    chk("s_diff", int'(s_diff), int'(e.sd));
                    chk("s_ovf", int'(s_ovf), int'(e.so));
                end
                model_cnt++;
            end
        end
    end

    task automatic send(input int idx);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_valid = 1'b1;
        a = vecs[idx].a;
        b = vecs[idx].b;
        while (!done) begin
            @(negedge clk);
            if (u_in_ready) begin
                exp_q.push_back(vecs[idx]);
                accepts++;
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: vector %0d got in_ready=0 for 50 cycles, expected accept", idx);
                done = 1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || u_out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //               a      b      u_sum  u_diff u_ovf  s_sum  s_diff s_ovf
        vecs[0]  = '{4'd9,  4'd1,  5'd10, 4'd8,  1'b0, 5'd26, 4'd8,  1'b0};
        vecs[1]  = '{4'd3,  4'd5,  5'd8,  4'd14, 1'b1, 5'd8,  4'd14, 1'b0};
        vecs[2]  = '{4'd15, 4'd15, 5'd30, 4'd0,  1'b0, 5'd30, 4'd0,  1'b0};
        vecs[3]  = '{4'd7,  4'd15, 5'd22, 4'd8,  1'b1, 5'd6,  4'd8,  1'b1};
        vecs[4]  = '{4'd8,  4'd8,  5'd16, 4'd0,  1'b0, 5'd16, 4'd0,  1'b0};
        vecs[5]  = '{4'd5,  4'd10, 5'd15, 4'd11, 1'b1, 5'd31, 4'd11, 1'b1};
        vecs[6]  = '{4'd1,  4'd2,  5'd3,  4'd15, 1'b1, 5'd3,  4'd15, 1'b0};
        vecs[7]  = '{4'd12, 4'd4,  5'd16, 4'd8,  1'b0, 5'd0,  4'd8,  1'b0};
        vecs[8]  = '{4'd0,  4'd0,  5'd0,  4'd0,  1'b0, 5'd0,  4'd0,  1'b0};
        vecs[9]  = '{4'd14, 4'd3,  5'd17, 4'd11, 1'b0, 5'd1,  4'd11, 1'b0};
        vecs[10] = '{4'd6,  4'd6,  5'd12, 4'd0,  1'b0, 5'd12, 4'd0,  1'b0};
        vecs[11] = '{4'd10, 4'd13, 5'd23, 4'd13, 1'b1, 5'd23, 4'd13, 1'b0};
        vecs[12] = '{4'd2,  4'd9,  5'd11, 4'd9,  1'b1, 5'd27, 4'd9,  1'b1};
        vecs[13] = '{4'd11, 4'd7,  5'd18, 4'd4,  1'b0, 5'd2,  4'd4,  1'b1};
        vecs[14] = '{4'd4,  4'd12, 5'd16, 4'd8,  1'b1, 5'd0,  4'd8,  1'b1};
        vecs[15] = '{4'd13, 4'd2,  5'd15, 4'd11, 1'b0, 5'd31, 4'd11, 1'b0};

        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        accepts   = 0;
        or_mode   = 1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(u_out_valid), 0);
        chk("rst_in_ready", int'(u_in_ready), 1);
        chk("rst_u_sum", int'(u_sum), 0);
        chk("rst_u_diff", int'(u_diff), 0);
        chk("rst_u_ovf", int'(u_ovf), 0);
        chk("rst_s_sum", int'(s_sum), 0);
        chk("rst_s_out_valid", int'(s_out_valid), 0);
        @(posedge clk);
        #1;

        // Directed arithmetic at full throughput
        for (int i = 0; i < 5; i++) send(i);
        idle();
        drain();
        chk("directed_count", model_cnt, 5);

        // Backpressure: two accepts, then in_ready low with S2 held stable
        or_mode = 0;
        accepts = 0;
        send(5);
        send(6);
        in_valid = 1'b1;
        a = vecs[7].a;
        b = vecs[7].b;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(u_in_ready), 0);
            chk("bp_out_valid", int'(u_out_valid), 1);
            chk("bp_u_sum_hold", int'(u_sum), int'(vecs[5].us));
            chk("bp_u_diff_hold", int'(u_diff), int'(vecs[5].ud));
            chk("bp_s_sum_hold", int'(s_sum), int'(vecs[5].ss));
            chk("bp_s_ovf_hold", int'(s_ovf), int'(vecs[5].so));
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", accepts, 2);
        or_mode = 1;
        for (int i = 7; i < 15; i++) send(i);
        idle();
        drain();
        chk("bp_count", model_cnt, 15);

        // Reset mid-flight with two pairs buffered
        or_mode = 0;
        send(0);
        send(1);
        idle();
        pulse_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", int'(u_out_valid), 0);
        chk("mid_rst_in_ready", int'(u_in_ready), 1);
        chk("mid_rst_u_done", int'(u_done_cnt), 0);
        chk("mid_rst_s_done", int'(s_done_cnt), 0);
        @(posedge clk);
        #1;
        or_mode = 1;
        send(15);
        idle();
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_results", model_cnt, 1);

        // Counter wrap on the 3-bit instance with random out_ready
        pulse_reset();
        or_mode = 2;
        for (int i = 0; i < 9; i++) send(i);
        idle();
        drain();
        or_mode = 1;
        @(posedge clk);
        #1;
        chk("wrap_model_cnt", model_cnt, 9);
        chk("wrap_u_done", int'(u_done_cnt), 1);
        chk("wrap_s_done", int'(s_done_cnt), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
